// File: rtl/iiitb_sipo_rx.sv
// Serial-in/parallel-out receiver. Line idles high; a frame is one start bit (0),
// WIDTH data bits LSB first, then one stop bit (1). One bit per clock, no
// oversampling. The received word is held for a valid/ready consumer.
module iiitb_sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;

  logic             w_last;
  logic             w_take;
  logic             w_free;

  // Frame sequencing and buffer-status decode
  always_comb begin
    w_state_nxt = r_state;
    w_last      = (r_cnt == CW'(WIDTH - 1));
    w_take      = r_valid && out_ready;
    w_free      = !r_valid || w_take;
    case (r_state)
      S_IDLE:  if (!data_in) w_state_nxt = S_DATA;
      S_DATA:  if (w_last) w_state_nxt = S_STOP;
      // Stop bit always returns to IDLE; a 0 here is a framing error, not a start bit
      S_STOP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, shift register, output buffer and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      if (w_take) r_valid <= 1'b0;
      case (r_state)
        S_IDLE: r_cnt <= '0;
        S_DATA: begin
          r_sreg <= {data_in, r_sreg[WIDTH-1:1]};
          r_cnt  <= r_cnt + CW'(1);
        end
        S_STOP: begin
          // A load here overrides the consume-clear above, so consume plus a new
          // word on the same edge leaves out_valid set
          if (data_in) begin
            if (w_free) begin
              r_data  <= r_sreg;
              r_valid <= 1'b1;
            end else begin
              r_ovr <= 1'b1;
            end
          end else begin
            r_ferr <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign data_out  = r_data;
  assign out_valid = r_valid;
  assign busy      = (r_state != S_IDLE);
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_iiitb_sipo_rx.sv
// Directed bench for iiitb_sipo_rx (WIDTH=4) with hand-computed expectations.
module tb_iiitb_sipo_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic       out_ready;
  logic [3:0] data_out;
  logic       out_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  iiitb_sipo_rx #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a complete frame; out_ready is raised only for the stop-bit edge when requested.
  // Returns frame_err/overrun as seen right after the stop edge.
  task automatic send_frame(input logic [3:0] d, input logic stop, input logic rdy_at_stop,
                            output logic ferr, output logic ovr);
    data_in = 1'b0;
    tick();
    check("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      data_in = d[i];
      tick();
    end
    check("busy_before_stop", busy, 1'b1);
    data_in   = stop;
    if (rdy_at_stop) out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    data_in   = 1'b1;
    ferr      = frame_err;
    ovr       = overrun;
    check("busy_after_stop", busy, 1'b0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_after_consume", out_valid, 1'b0);
  endtask

  logic fe, ov;
  logic any_bad;

  initial begin
    rst = 1'b1; data_in = 1'b1; out_ready = 1'b0;
    tick(); tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", data_out, 4'h0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst = 1'b0;

    // 1. idle line
    any_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy || out_valid || frame_err || overrun) any_bad = 1'b1;
    end
    check("idle_quiet", any_bad, 1'b0);

    // 2. 4'hA held until accepted
    send_frame(4'hA, 1'b1, 1'b0, fe, ov);
    check("t2_valid", out_valid, 1'b1);
    check("t2_data", data_out, 4'hA);
    check("t2_ferr", fe, 1'b0);
    check("t2_ovr", ov, 1'b0);
    tick(); tick(); tick();
    check("t2_hold_valid", out_valid, 1'b1);
    check("t2_hold_data", data_out, 4'hA);
    consume();

    // 3. bad stop bit: data 1,1,0,0 = 4'h3
    send_frame(4'h3, 1'b0, 1'b0, fe, ov);
    check("t3_ferr", fe, 1'b1);
    check("t3_ovr", ov, 1'b0);
    check("t3_valid", out_valid, 1'b0);
    tick();
    check("t3_ferr_pulse_end", frame_err, 1'b0);
    any_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy || out_valid) any_bad = 1'b1;
    end
    check("t3_stays_idle", any_bad, 1'b0);

    // 4. back-to-back with buffer full -> overrun
    send_frame(4'h3, 1'b1, 1'b0, fe, ov);
    check("t4_first_data", data_out, 4'h3);
    check("t4_first_valid", out_valid, 1'b1);
    send_frame(4'hC, 1'b1, 1'b0, fe, ov);
    check("t4_ovr", ov, 1'b1);
    check("t4_ferr", fe, 1'b0);
    check("t4_data_kept", data_out, 4'h3);
    check("t4_valid", out_valid, 1'b1);
    tick();
    check("t4_ovr_pulse_end", overrun, 1'b0);
    consume();

    // 5. consume on the second stop edge -> new word, no overrun
    send_frame(4'h3, 1'b1, 1'b0, fe, ov);
    check("t5_first_data", data_out, 4'h3);
    send_frame(4'hC, 1'b1, 1'b1, fe, ov);
    check("t5_ovr", ov, 1'b0);
    check("t5_data", data_out, 4'hC);
    check("t5_valid", out_valid, 1'b1);
    consume();

    // 6. reset during third data bit of 4'h5 (bits 1,0,1,0)
    data_in = 1'b0; tick();
    data_in = 1'b1; tick();
    data_in = 1'b0; tick();
    data_in = 1'b1; rst = 1'b1; tick();
    rst = 1'b0;
    check("t6_busy", busy, 1'b0);
    check("t6_valid", out_valid, 1'b0);
    check("t6_pulses", {frame_err, overrun}, 2'b00);
    tick();
    send_frame(4'h5, 1'b1, 1'b0, fe, ov);
    check("t6_data", data_out, 4'h5);
    check("t6_valid_after", out_valid, 1'b1);
    check("t6_frame_pulses", {fe, ov}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
